sar_search_nbit: RTL and testbench
==================================

// Module: sar_search_nbit
// PURPOSE
//   Successive-approximation search engine. It is the initiator side of an
//   N-bit comparator: it drives a registered trial operand, reads back the
//   comparator's Lesser/Greater/Equal flags, and converges on the target value
//   one bit per clock. Used for threshold search and for value recovery
//   against an external comparator_nbit instance.
// PARAMETERS
//   n        32   operand/trial/result width in bits (n >= 2)
// PORTS
//   clk          in   1   rising-edge clock (single clock domain)
//   rst          in   1   asynchronous, active-high reset
//   start        in   1   begin search; sampled only in IDLE/DONE
//   cmp_lesser   in   1   comparator flag: target < trial
//   cmp_greater  in   1   comparator flag: target > trial
//   cmp_equal    in   1   comparator flag: target == trial
//   trial        out  n   registered operand driven into the comparator
//   busy         out  1   high while a search is in progress
//   done         out  1   one-cycle pulse when result is valid
//   result       out  n   final value; held until the next start
//   flag_err     out  1   flags not one-hot during the search; cleared by start
// BEHAVIOUR
//   Reset: state=IDLE; trial=0, result=0, busy=0, done=0, flag_err=0, ptr=n-1.
//   FSM states: IDLE -> PROBE -> DONE -> (start) PROBE | (no start) IDLE.
//   - IDLE/DONE, start=1 at edge E0: trial<=1<<(n-1), ptr<=n-1, busy<=1,
//     flag_err<=0, state<=PROBE. done returns to 0 on the next cycle.
//   - PROBE, each edge Ek (k=1..n): sample flags for the current trial.
//       flags not one-hot (0 or >1 set): flag_err<=1, result<=trial,
//         abort to DONE.
//       cmp_lesser: clear trial[ptr]. Otherwise keep trial[ptr].
//       ptr==0: result<=decided trial, state<=DONE.
//       else: set trial[ptr-1], ptr<=ptr-1.
//   - DONE lasts exactly one cycle with done=1 and busy=0, then goes to IDLE.
//     start during DONE is honoured, giving a back-to-back search.
//   Latency: start at E0 -> done high after En (n comparisons); 1 search per n+1.
//   Comparator is combinational: flags must be settled within the same cycle
//   from trial. No pipelining of the flags.
//   start during PROBE: ignored; the search is not restarted.
//   Boundaries: target 0 -> every bit cleared, result 0. Target 2^n-1 -> no bit
//     cleared, result all-ones. The bit at ptr 0 is decided on its own compare.
//   Reset mid-search: abort immediately to the reset values. No done pulse.
//   All arithmetic is unsigned. trial never exceeds n bits. No wrap-around.
// CONFIGURATION
//   SAR_EARLY_EXIT_EN defined: in PROBE, cmp_equal=1 (one-hot) -> result<=trial,
//     state<=DONE at that edge. Latency is then k comparisons for an exact
//     match at step k.
//   Undefined: cmp_equal is treated as "not lesser" (bit kept). The search
//     always takes n comparisons. The result value is identical in both modes.
// STRUCTURE
//   Shared package sar_pkg: state encoding localparams (S_IDLE, S_PROBE,
//     S_DONE) and the flag-check function onehot3(l,g,e).
//   Sub-module sar_bit_ptr: down-counter ptr plus one-hot bit-mask generator
//     (load n-1, decrement, last flag).
//   Top level holds the FSM, the trial/result registers and the status outputs.
// TESTING (bench: n=8, loop-back through comparator_nbit #(8), target as a)
//   target 0xA5, pulse start -> trial sequence 80,C0,A0,B0,A8,A4,A6,A5;
//     done after 8 edges; result=0xA5; flag_err=0.
//   targets 0x00 and 0xFF -> result 0x00 / 0xFF after 8 compares; busy low
//     with done.
//   target 0x80: with SAR_EARLY_EXIT_EN -> done after 1 compare; without ->
//     done after 8. result=0x80 in both.
//   Force cmp_lesser=cmp_greater=1 at the 3rd compare -> flag_err=1, done
//     pulse, result=trial at abort (0xA0 for target 0xA5).
//   start re-pulsed during PROBE -> ignored, unchanged 8-cycle completion.
//     rst high at compare 4 -> all outputs 0 on the next sample, no done pulse.
//   start held high through DONE -> second search begins; done pulses every
//     9 cycles.

Source files
------------

// File: rtl/sar_pkg.sv
// sar_pkg: shared FSM state encoding and flag-validity check for the SAR search engine
package sar_pkg;
    typedef enum logic [1:0] {S_IDLE, S_PROBE, S_DONE} state_t;
    function automatic logic onehot3(input logic l, input logic g, input logic e);
        return (l ^ g ^ e) & ~(l & g & e);
    endfunction
endpackage

// File: rtl/sar_bit_ptr.sv
// sar_bit_ptr: bit pointer for the SAR search, counting n-1 down to 0 with a one-hot mask and last flag
module sar_bit_ptr #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_dec,
    output logic [n-1:0] o_mask,
    output logic         o_last
);
    localparam logic [$clog2(n)-1:0] TOP = $clog2(n)'(n - 1);
    logic [$clog2(n)-1:0] r_ptr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ptr <= TOP;
        else if (i_load) r_ptr <= TOP;
        else if (i_dec) r_ptr <= r_ptr - 1'b1;
    end
    assign o_mask = {{(n-1){1'b0}}, 1'b1} << r_ptr;
    assign o_last = r_ptr == '0;
endmodule

// File: rtl/sar_search_nbit.sv
// sar_search_nbit: successive-approximation search driving an external comparator, one bit per clock.
// Define SAR_EARLY_EXIT_EN to finish as soon as the comparator reports an exact match.
module sar_search_nbit
    import sar_pkg::*;
#(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         cmp_lesser,
    input  logic         cmp_greater,
    input  logic         cmp_equal,
    output logic [n-1:0] trial,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] result,
    output logic         flag_err
);
    localparam logic [n-1:0] MSB = {1'b1, {(n-1){1'b0}}};
    state_t       r_state;
    logic [n-1:0] r_trial, r_result;
    logic         r_busy, r_done, r_flag_err;
    logic [n-1:0] w_mask, w_decided;
    logic         w_last, w_onehot, w_load, w_dec;
    assign w_onehot  = onehot3(cmp_lesser, cmp_greater, cmp_equal);
    assign w_decided = cmp_lesser ? (r_trial & ~w_mask) : r_trial;
    assign w_load    = (r_state != S_PROBE) && start;
    assign w_dec     = (r_state == S_PROBE) && !w_last;
    sar_bit_ptr #(.n(n)) u_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_load(w_load),
        .i_dec (w_dec),
        .o_mask(w_mask),
        .o_last(w_last)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_trial    <= '0;
            r_result   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_flag_err <= 1'b0;
        end else if (r_state == S_PROBE) begin
            if (!w_onehot) begin
                r_flag_err <= 1'b1;
                r_result   <= r_trial;
                r_busy     <= 1'b0;
                r_done     <= 1'b1;
                r_state    <= S_DONE;
`ifdef SAR_EARLY_EXIT_EN
            end else if (cmp_equal) begin
                r_result <= r_trial;
                r_busy   <= 1'b0;
                r_done   <= 1'b1;
                r_state  <= S_DONE;
`endif
            end else if (w_last) begin
                r_trial  <= w_decided;
                r_result <= w_decided;
                r_busy   <= 1'b0;
                r_done   <= 1'b1;
                r_state  <= S_DONE;
            end else begin
                r_trial <= w_decided | (w_mask >> 1);
            end
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_trial    <= MSB;
                r_busy     <= 1'b1;
                r_flag_err <= 1'b0;
                r_state    <= S_PROBE;
            end else begin
                r_state <= S_IDLE;
            end
        end
    end
    assign trial    = r_trial;
    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;
    assign flag_err = r_flag_err;
endmodule

// File: tb/tb_sar_search_nbit.sv
// tb_sar_search_nbit: directed vectors for the 8-bit SAR search with a behavioural comparator in loop-back
module tb_sar_search_nbit;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic       cmp_lesser, cmp_greater, cmp_equal;
    logic [7:0] trial, result, target = 8'h00;
    logic       busy, done, flag_err;
    logic       ovr = 1'b0, ovr_l = 1'b0, ovr_g = 1'b0, ovr_e = 1'b0;
    int         errors = 0, checks = 0;

    always #5 clk = ~clk;

    assign cmp_lesser  = ovr ? ovr_l : (target < trial);
    assign cmp_greater = ovr ? ovr_g : (target > trial);
    assign cmp_equal   = ovr ? ovr_e : (target == trial);

    sar_search_nbit #(.n(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cmp_lesser(cmp_lesser), .cmp_greater(cmp_greater), .cmp_equal(cmp_equal),
        .trial(trial), .busy(busy), .done(done), .result(result), .flag_err(flag_err)
    );

    typedef struct {
        logic [7:0] tgt;
        logic [7:0] exp_res;
        int         exp_cyc;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one edge, then counts edges until done (bounded).
    task automatic run_search(input logic [7:0] tgt, output int cyc);
        target = tgt;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    vec_t       vecs[7];
    logic [7:0] seq[8];
    int         cyc;
    int         done_at[$];

    initial begin
        vecs[0] = '{8'hA5, 8'hA5, 8};
        vecs[1] = '{8'h00, 8'h00, 8};
        vecs[2] = '{8'hFF, 8'hFF, 8};
`ifdef SAR_EARLY_EXIT_EN
        vecs[3] = '{8'h80, 8'h80, 1};
`else
        vecs[3] = '{8'h80, 8'h80, 8};
`endif
        vecs[4] = '{8'h01, 8'h01, 8};
        vecs[5] = '{8'h7F, 8'h7F, 8};
        vecs[6] = '{8'h5B, 8'h5B, 8};
        seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

        #2;
        chk("reset_trial", int'(trial), 0);
        chk("reset_result", int'(result), 0);
        chk("reset_status", int'({busy, done, flag_err}), 0);
        tick();
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            run_search(vecs[i].tgt, cyc);
            chk($sformatf("result_%02h", vecs[i].tgt), int'(result), int'(vecs[i].exp_res));
            chk($sformatf("cycles_%02h", vecs[i].tgt), cyc, vecs[i].exp_cyc);
            chk($sformatf("status_%02h", vecs[i].tgt), int'({busy, flag_err}), 0);
            tick();
            chk($sformatf("done_pulse_%02h", vecs[i].tgt), int'(done), 0);
        end

        target = 8'hA5;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("trial_step%0d", k + 1), int'(trial), int'(seq[k]));
            chk($sformatf("busy_step%0d", k + 1), int'(busy), 1);
            tick();
        end
        chk("seq_done", int'(done), 1);
        chk("seq_result", int'(result), 8'hA5);
        tick();

        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("err_trial_before", int'(trial), 8'hA0);
        ovr = 1'b1; ovr_l = 1'b1; ovr_g = 1'b1; ovr_e = 1'b0;
        tick();
        ovr = 1'b0;
        chk("err_flag", int'(flag_err), 1);
        chk("err_done", int'(done), 1);
        chk("err_busy", int'(busy), 0);
        chk("err_result", int'(result), 8'hA0);
        tick();
        chk("err_done_drop", int'(done), 0);
        chk("err_flag_held", int'(flag_err), 1);
        run_search(8'h3C, cyc);
        chk("err_cleared", int'(flag_err), 0);
        chk("err_clear_result", int'(result), 8'h3C);
        tick();

        target = 8'hA5;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 3;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("restart_ignored_cycles", cyc, 8);
        chk("restart_ignored_result", int'(result), 8'hA5);
        tick();

        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("rst_trial", int'(trial), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_status", int'({busy, done, flag_err}), 0);
        cyc = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            cyc += int'(done);
        end
        chk("rst_no_done", cyc, 0);
        rst = 1'b0;
        tick();

        target = 8'hC3;
        start = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (done) done_at.push_back(t - 1);
            if (t == 10) chk("b2b_busy", int'(busy), 1);
        end
        start = 1'b0;
        chk("b2b_count", done_at.size(), 2);
        if (done_at.size() >= 2) begin
            chk("b2b_first", done_at[0], 8);
            chk("b2b_second", done_at[1], 17);
        end
        chk("b2b_result", int'(result), 8'hC3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
